// File: rtl/note_decoder.sv
// note_decoder: 88-key piano note number to an 8-bit tone sample stream at 100 MHz.
// A 24-bit phase accumulator advances by a per-key increment. The top phase
// byte forms a rising sawtooth.
// Build option: define NOTE_DECODER_SQUARE_EN to emit a 50 % square wave
// (8'h00 / 8'hFF) taken from the phase MSB instead of the sawtooth.
// Silence (disabled or invalid note) is always 8'h00.
module note_decoder (
  input  logic [9:0] note,
  input  logic       clk,
  input  logic       enable,
  output logic [7:0] out,
  input  logic       rst_n
);

  // Octave-7 increments (keys 85..96): round(3520 * 2^(s/12) * 2^24 / 1e8).
  function automatic logic [10:0] base_inc(input logic [3:0] s);
    logic [10:0] b;
    case (s)
      4'd0:    b = 11'd591;
      4'd1:    b = 11'd626;
      4'd2:    b = 11'd663;
      4'd3:    b = 11'd702;
      4'd4:    b = 11'd744;
      4'd5:    b = 11'd788;
      4'd6:    b = 11'd835;
      4'd7:    b = 11'd885;
      4'd8:    b = 11'd937;
      4'd9:    b = 11'd993;
      4'd10:   b = 11'd1052;
      default: b = 11'd1115;
    endcase
    return b;
  endfunction

  // Divide by 12 via multiply-by-171 and shift by 11. The error stays below
  // one LSB over n = 0..87, so the quotient is exact in that range.
  function automatic logic [23:0] note_inc(input logic [9:0] nt);
    logic [6:0]  n;
    logic [14:0] prod;
    logic [2:0]  o;
    logic [3:0]  s;
    n    = 7'(nt - 10'd1);
    prod = 15'(n) * 15'd171;
    o    = 3'(prod >> 11);
    s    = 4'(n - 7'(o) * 7'd12);
    return {13'd0, base_inc(s) >> (3'd7 - o)};
  endfunction

  logic        vld_p0;
  logic [23:0] inc_q;
  logic [23:0] phase;

  assign vld_p0 = enable && (note != 10'd0) && (note <= 10'd88);

  // Increment register feeding the accumulator; both clear on silence so a re-enable restarts at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= 24'd0;
      phase <= 24'd0;
    end else if (vld_p0) begin
      inc_q <= note_inc(note);
      phase <= phase + inc_q;
    end else begin
      inc_q <= 24'd0;
      phase <= 24'd0;
    end
  end

  // Output shaping straight off the phase register
`ifdef NOTE_DECODER_SQUARE_EN
  assign out = {8{phase[23]}};
`else
  assign out = phase[23:16];
`endif

endmodule

// File: tb/tb_note_decoder.sv
// Randomized and directed bench for note_decoder with a queue-based tone model.
`timescale 1ns/1ps
module tb_note_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] note;
  logic       enable;
  logic [7:0] out;

  int vectors = 0;
  int miscompares = 0;

  int unsigned base_tab [12] = '{591, 626, 663, 702, 744, 788, 835, 885, 937, 993, 1052, 1115};
  // Increment chosen at each active edge since the last silent edge.
  int unsigned run_q [$];

  always #5 clk = ~clk;

  note_decoder dut (
    .note   (note),
    .clk    (clk),
    .enable (enable),
    .out    (out),
    .rst_n  (rst_n)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  function automatic int unsigned ref_inc(input int unsigned nt, input bit en);
    if (!en || nt < 1 || nt > 88) return 0;
    return base_tab[(nt - 1) % 12] >> (7 - (nt - 1) / 12);
  endfunction

  // Phase after an edge is the sum of every earlier increment of the current run.
  function automatic logic [23:0] exp_phase();
    longint unsigned sum = 0;
    for (int i = 0; i + 1 < run_q.size(); i++) sum += run_q[i];
    return 24'(sum);
  endfunction

  function automatic logic [23:0] exp_inc();
    if (run_q.size() == 0) return 24'd0;
    return 24'(run_q[run_q.size() - 1]);
  endfunction

  function automatic logic [7:0] ref_out(input logic [23:0] ph);
`ifdef NOTE_DECODER_SQUARE_EN
    return {8{ph[23]}};
`else
    return ph[23:16];
`endif
  endfunction

  // Advance one rising edge, record it in the model, return at the falling edge.
  task automatic step();
    int unsigned i;
    @(posedge clk);
    i = ref_inc(note, enable);
    if (!rst_n || i == 0) run_q.delete();
    else run_q.push_back(i);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; note = 10'd88; enable = 1'b1;
    #1;
    vectors++;
    if (out !== 8'h00) begin miscompares++; $display("FAIL reset_t0: out=%0d expected 0", out); end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (out !== 8'h00) begin miscompares++; $display("FAIL reset_out: out=%0d expected 0", out); end
      vectors++;
      if (dut.inc_q !== 24'd0) begin miscompares++; $display("FAIL reset_inc: inc_q=%0d expected 0", dut.inc_q); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_top_note();
    for (int k = 0; k < 1001; k++) step();
    vectors++;
    if (dut.inc_q !== 24'd702) begin miscompares++; $display("FAIL top_inc: inc_q=%0d expected 702", dut.inc_q); end
    vectors++;
    if (dut.phase !== 24'd702000) begin miscompares++; $display("FAIL top_phase: phase=%0d expected 702000", dut.phase); end
    vectors++;
`ifdef NOTE_DECODER_SQUARE_EN
    if (out !== 8'h00) begin miscompares++; $display("FAIL top_out: out=%0d expected 0", out); end
`else
    if (out !== 8'd10) begin miscompares++; $display("FAIL top_out: out=%0d expected 10", out); end
`endif
    // Asynchronous reset in the middle of a tone, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out !== 8'h00 || dut.phase !== 24'd0) begin
      miscompares++; $display("FAIL async_reset: out=%0d phase=%0d expected 0/0", out, dut.phase);
    end
    run_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_increments();
    int unsigned keys [7] = '{49, 12, 1, 22, 44, 60, 70};
    int unsigned incs [7] = '{73, 8, 4, 15, 55, 139, 248};
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      note = 10'(keys[i]);
      step();
      vectors++;
      if (dut.inc_q !== 24'(incs[i])) begin
        miscompares++; $display("FAIL inc_note%0d: inc_q=%0d expected %0d", keys[i], dut.inc_q, incs[i]);
      end
      step(); step();
      vectors++;
      if (dut.phase !== exp_phase()) begin
        miscompares++; $display("FAIL inc_phase%0d: phase=%0d expected %0d", keys[i], dut.phase, exp_phase());
      end
    end
  endtask

  task automatic test_invalid();
    logic [9:0] bad [3] = '{10'd0, 10'd89, 10'd1023};
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; note = 10'd60;
      repeat (5) step();
      if (i < 3) note = bad[i];
      else enable = 1'b0;
      step();
      vectors++;
      if (dut.inc_q !== 24'd0 || out !== 8'h00 || dut.phase !== 24'd0) begin
        miscompares++;
        $display("FAIL silence_case%0d: inc_q=%0d out=%0d phase=%0d expected 0/0/0", i, dut.inc_q, out, dut.phase);
      end
    end
  endtask

  task automatic test_note_step();
    logic [23:0] p0, p1, p2, p3;
    enable = 1'b1; note = 10'd88;
    repeat (50) step();
    p0 = dut.phase;
    note = 10'd87;
    step(); p1 = dut.phase;
    step(); p2 = dut.phase;
    step(); p3 = dut.phase;
    vectors++;
    if (p1 - p0 !== 24'd702) begin miscompares++; $display("FAIL step_edge1: delta=%0d expected 702", p1 - p0); end
    vectors++;
    if (p2 - p1 !== 24'd663) begin miscompares++; $display("FAIL step_edge2: delta=%0d expected 663", p2 - p1); end
    vectors++;
    if (p3 - p2 !== 24'd663) begin miscompares++; $display("FAIL step_edge3: delta=%0d expected 663", p3 - p2); end
    vectors++;
    if (p3 !== 24'(702 * 50 + 663 * 2)) begin
      miscompares++; $display("FAIL step_continuity: phase=%0d expected %0d", p3, 702 * 50 + 663 * 2);
    end
  endtask

  task automatic test_wrap();
    enable = 1'b0;
    step();
    enable = 1'b1; note = 10'd88;
    for (int k = 1; k <= 23901; k++) begin
      step();
      if (k == 23900) begin
        vectors++;
        if (dut.phase !== 24'd16777098 || out !== ref_out(24'd16777098)) begin
          miscompares++; $display("FAIL wrap_before: phase=%0d out=%0d expected 16777098/%0d", dut.phase, out, ref_out(24'd16777098));
        end
      end
    end
    vectors++;
    if (dut.phase !== 24'd584 || out !== 8'h00) begin
      miscompares++; $display("FAIL wrap_after: phase=%0d out=%0d expected 584/0", dut.phase, out);
    end
    run_q.delete();
  endtask

  task automatic test_random();
    int hold = 0;
    enable = 1'b0;
    step();
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        hold = int'($urandom_range(1, 12));
        if ($urandom_range(0, 19) == 0) note = 10'($urandom_range(89, 1023));
        else if ($urandom_range(0, 29) == 0) note = 10'd0;
        else note = 10'($urandom_range(1, 88));
      end
      hold--;
      enable = ($urandom_range(0, 19) != 0);
      step();
      vectors++;
      if (dut.inc_q !== exp_inc() || dut.phase !== exp_phase() || out !== ref_out(exp_phase())) begin
        miscompares++;
        $display("FAIL random_c%0d: inc_q=%0d phase=%0d out=%0d expected %0d/%0d/%0d",
                 c, dut.inc_q, dut.phase, out, exp_inc(), exp_phase(), ref_out(exp_phase()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_top_note();
    test_increments();
    test_invalid();
    test_note_step();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
